param_modn_counter: RTL and testbench
=====================================

// Module: param_modn_counter
// PURPOSE
//  Parametrised programmable modulo-N counter. Counts over the range 0..N-1 with
//  runtime-selectable up, down, bounce (up/down ping-pong) and hold modes.
//  Adds clock enable, parallel load, a direction output, a terminal-count pulse
//  and a saturating wrap-event counter. Drives lab display, timer and sequencer
//  blocks in place of fixed 4-bit counters.
// PARAMETERS
//  WIDTH    4  width of count, n and load_val
//  WRAP_W   8  width of the wrap-event counter wrap_cnt
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        synchronous, active-low reset
//  en        in   1        count enable; a step occurs only when en=1
//  load      in   1        parallel load strobe; overrides en
//  load_val  in   WIDTH    value loaded into count
//  mode      in   2        00 up, 01 down, 10 bounce, 11 hold
//  n         in   WIDTH    modulus; range is 0..n-1; n=0 means 2^WIDTH
//  wrap_clr  in   1        clears wrap_cnt
//  count     out  WIDTH    current count (registered)
//  dir       out  1        1 = ascending, 0 = descending (registered)
//  tc        out  1        one-cycle terminal-count pulse (registered)
//  wrap_cnt  out  WRAP_W   number of tc events, saturating (registered)
// BEHAVIOUR
//  - Reset (reset=0 at posedge): count=0, dir=1, tc=0, wrap_cnt=0. Reset mid-count
//    takes effect at that edge; all other inputs are ignored that cycle.
//  - Priority per edge: reset > load > (en & step) > hold. wrap_clr is independent.
//  - Let M = (n==0) ? 2^WIDTH : n; TOP = M-1. All arithmetic is modulo 2^WIDTH.
//  - load=1: count<=load_val, tc<=0, dir unchanged; en is ignored.
//  - en=0 or mode=11: count and dir hold; tc<=0.
//  - mode 00 (up), en=1: count==TOP or count>TOP -> count<=0, tc<=1;
//    else count+1, tc<=0. dir<=1.
//  - mode 01 (down), en=1: count==0 -> count<=TOP, tc<=1;
//    count>TOP -> count<=TOP, tc<=0; else count-1, tc<=0. dir<=0.
//  - mode 10 (bounce), en=1: sequence 0,1..TOP,TOP-1..0,1..; endpoints are not
//    repeated. dir=1 and count>=TOP -> count<=TOP-1, dir<=0, tc<=1.
//    dir=0 and count==0 -> count<=1, dir<=1, tc<=1. Otherwise step in dir,
//    tc<=0. count>TOP while descending -> count<=TOP, tc<=0.
//  - M==1: count stays 0 in every mode; tc<=1 on every enabled step except hold.
//    dir holds in bounce.
//  - M==2 bounce: 0,1,0,1..., with tc=1 on every enabled step.
//  - Mode change between cycles: the new mode applies from the next edge using the
//    current count. Entering bounce keeps the current dir.
//  - n change mid-count: takes effect immediately. Out-of-range counts resolve per
//    the rules above; they never run past TOP.
//  - tc is high only for the cycle following the wrapping or turning edge.
//  - wrap_cnt: wrap_clr=1 -> 0; else if the edge sets tc<=1 -> +1, saturating at
//    2^WRAP_W-1. When wrap_clr and a tc event coincide, the clear wins.
//  - Latency: all outputs update on the same edge as the causing input; no
//    combinational path from inputs to outputs.
// TESTING (WIDTH=4, WRAP_W=8 unless stated)
//  1 reset=0 for 2 cycles, then mode=00, n=10, en=1 for 25 cycles -> count 0..9,0..9,0..4;
//    tc high the cycle count=0 after each 9; wrap_cnt=2.
//  2 mode=01, n=6, load_val=2, load 1 cycle, then en=1 -> 2,1,0,5,4..;
//    tc with the first 5; dir=0.
//  3 mode=10, n=4 from count=0 -> 1,2,3,2,1,0,1; tc at each 3->2 and 0->1 turn;
//    dir toggles there. n=1 -> count fixed at 0, tc every cycle.
//  4 count=12, n changed to 8: mode 00 -> next 0 with tc=1; mode 01 -> next 7 with tc=0;
//    n=0, mode 00 -> full 0..15 wrap.
//  5 Priority: load=1 & en=1 -> load_val taken; reset=0 & load=1 -> 0; en=0 -> hold,
//    tc=0; reset asserted at count=5 in bounce -> count=0, dir=1.
//  6 WRAP_W=2: 5 wraps -> wrap_cnt saturates at 3; wrap_clr coinciding with tc -> 0.

Source files
------------

// File: rtl/param_modn_counter_if.sv
// ----------------------------------------------------------------------------
// param_modn_counter_if
//
// Purpose:
//   Bundles the control inputs and status outputs of param_modn_counter so
//   the counter and its user connect through one port.
//
//   There is no valid/ready handshake on this bus. Every input is sampled on
//   every rising clock edge. "en" qualifies a counting step for that edge
//   only, and "load" and "wrap_clr" act only on the edge where they are 1.
//   Every output is registered and changes only on a clock edge.
//
// Signals (direction seen from the counter, i.e. the slave modport):
//   en        in   1        count enable for this edge
//   load      in   1        parallel load strobe; overrides en
//   load_val  in   WIDTH    value taken by count on load
//   mode      in   2        00 up, 01 down, 10 bounce, 11 hold
//   n         in   WIDTH    modulus; 0 means 2^WIDTH
//   wrap_clr  in   1        clears wrap_cnt
//   count     out  WIDTH    current count
//   dir       out  1        1 ascending, 0 descending (counter direction state)
//   tc        out  1        terminal-count pulse
//   wrap_cnt  out  WRAP_W   saturating count of tc events
// ----------------------------------------------------------------------------
interface param_modn_counter_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
);
    logic              en;
    logic              load;
    logic [WIDTH-1:0]  load_val;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  n;
    logic              wrap_clr;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;

    // The user of the counter drives the controls and reads the status.
    modport master (
        output en, load, load_val, mode, n, wrap_clr,
        input  count, dir, tc, wrap_cnt
    );

    // The counter itself.
    modport slave (
        input  en, load, load_val, mode, n, wrap_clr,
        output count, dir, tc, wrap_cnt
    );
endinterface

// File: rtl/param_modn_counter.sv
// ----------------------------------------------------------------------------
// param_modn_counter
//
// Purpose:
//   Programmable modulo-N counter over 0..M-1, where M = n, or 2^WIDTH when
//   n = 0. The counting mode is selected at run time: up, down, bounce
//   (ping-pong without repeating the endpoints) or hold. The counter also
//   provides a parallel load, a direction output, a one-cycle terminal-count
//   pulse, and a saturating count of terminal-count events.
//
// Ports:
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous reset, active low
//   bus    slave modport of param_modn_counter_if (controls in, status out)
//
// Priority on each edge: reset > load > enabled step > hold.
// wrap_clr is evaluated on its own; when it coincides with a tc event, the
// clear wins.
//
// The direction register is the only state that controls the sequence. It
// is a small two-state machine (DIR_UP / DIR_DOWN), and bus.dir always shows
// its current state.
// ----------------------------------------------------------------------------
module param_modn_counter #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    param_modn_counter_if.slave  bus
);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0]  count_q, count_d;
    dir_e              dir_q, dir_d;
    logic              tc_q, tc_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    // TOP = M-1. Because the subtraction is done modulo 2^WIDTH, n = 0 wraps
    // to all ones, which is exactly TOP for M = 2^WIDTH. No special case is
    // needed for n = 0.
    logic [WIDTH-1:0] top;
    logic             m_is_one;
    logic             at_zero;
    logic             at_or_past_top;
    logic             past_top;

    assign top            = bus.n - CNT_ONE;
    assign m_is_one       = (bus.n == CNT_ONE);
    assign at_zero        = (count_q == '0);
    assign at_or_past_top = (count_q >= top);
    assign past_top       = (count_q > top);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q    <= '0;
            dir_q      <= DIR_UP;
            tc_q       <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            dir_q      <= dir_d;
            tc_q       <= tc_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic for count, direction and terminal count
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;

        if (bus.load) begin
            // A load keeps the current direction. A later bounce then
            // continues in the direction the counter was already moving.
            count_d = bus.load_val;
        end else if (bus.en) begin
            unique case (bus.mode)
                MODE_UP: begin
                    dir_d = DIR_UP;
                    // An out-of-range count wraps straight to 0, so the
                    // counter never climbs past TOP.
                    if (at_or_past_top) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end

                MODE_DOWN: begin
                    dir_d = DIR_DOWN;
                    if (m_is_one) begin
                        // A one-state range: every enabled step is a wrap.
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else if (at_zero) begin
                        count_d = top;
                        tc_d    = 1'b1;
                    end else if (past_top) begin
                        // Pull back into range without reporting a wrap.
                        count_d = top;
                    end else begin
                        count_d = count_q - CNT_ONE;
                    end
                end

                MODE_BOUNCE: begin
                    if (m_is_one) begin
                        // There is nowhere to turn to. The count stays at 0,
                        // each step counts as a turn, and dir is kept.
                        count_d = '0;
                        tc_d    = 1'b1;
                    end else if (dir_q == DIR_UP) begin
                        if (at_or_past_top) begin
                            // Turn at the top. The next value is TOP-1, so
                            // TOP appears only once.
                            count_d = top - CNT_ONE;
                            dir_d   = DIR_DOWN;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end else begin
                        if (past_top) begin
                            count_d = top;
                        end else if (at_zero) begin
                            // Turn at the bottom. The next value is 1, so 0
                            // appears only once.
                            count_d = CNT_ONE;
                            dir_d   = DIR_UP;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end
                end

                default: begin
                    // Hold mode: count and dir keep their values, tc stays 0.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Wrap-event counter: counts the same edges that set tc, saturates at
    // all ones, and a clear has priority over an increment.
    // ------------------------------------------------------------------
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        if (bus.wrap_clr) begin
            wrap_cnt_d = '0;
        end else if (tc_d && (wrap_cnt_q != WRAP_MAX)) begin
            wrap_cnt_d = wrap_cnt_q + WRAP_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Outputs come straight from the registers.
    // ------------------------------------------------------------------
    assign bus.count    = count_q;
    assign bus.dir      = dir_q;
    assign bus.tc       = tc_q;
    assign bus.wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_param_modn_counter.sv
// ----------------------------------------------------------------------------
// tb_param_modn_counter
//
// Drives two counters (WRAP_W=8 and WRAP_W=2) with identical stimulus and
// checks every cycle against an integer reference model. The bench runs
// directed scenarios first and then a randomized phase.
// ----------------------------------------------------------------------------
module tb_param_modn_counter;

    localparam int W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- stimulus variables ----------------
    logic          en, load, wrap_clr;
    logic [W-1:0]  load_val, n;
    logic [1:0]    mode;

    param_modn_counter_if #(.WIDTH(W), .WRAP_W(8)) bus8 ();
    param_modn_counter_if #(.WIDTH(W), .WRAP_W(2)) bus2 ();

    assign bus8.en = en;        assign bus2.en = en;
    assign bus8.load = load;    assign bus2.load = load;
    assign bus8.load_val = load_val; assign bus2.load_val = load_val;
    assign bus8.mode = mode;    assign bus2.mode = mode;
    assign bus8.n = n;          assign bus2.n = n;
    assign bus8.wrap_clr = wrap_clr; assign bus2.wrap_clr = wrap_clr;

    param_modn_counter #(.WIDTH(W), .WRAP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    param_modn_counter #(.WIDTH(W), .WRAP_W(2)) dut_w2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    // ---------------- reference model ----------------
    // The model keeps the count as an integer and TOP as M-1 in plain
    // arithmetic. The bounce direction is a separate flag.
    int m_count;
    bit m_dir;
    bit m_tc;
    int m_wc8;
    int m_wc2;

    task automatic model_update();
        int mod_m;
        int top;
        if (!reset) begin
            m_count = 0; m_dir = 1; m_tc = 0; m_wc8 = 0; m_wc2 = 0;
            return;
        end
        mod_m = (n == 0) ? (1 << W) : int'(n);
        top   = mod_m - 1;
        m_tc  = 0;
        if (load) begin
            m_count = int'(load_val);
        end else if (en && mode != 2'b11) begin
            if (mod_m == 1) begin
                // A one-state range: the count stays 0 and every step is a wrap.
                m_count = 0;
                m_tc    = 1;
                if (mode == 2'b00) m_dir = 1;
                if (mode == 2'b01) m_dir = 0;
            end else if (mode == 2'b00) begin
                m_dir = 1;
                if (m_count >= top) begin m_count = 0; m_tc = 1; end
                else m_count = m_count + 1;
            end else if (mode == 2'b01) begin
                m_dir = 0;
                if (m_count == 0) begin m_count = top; m_tc = 1; end
                else if (m_count > top) m_count = top;
                else m_count = m_count - 1;
            end else begin
                if (m_dir) begin
                    if (m_count >= top) begin m_count = top - 1; m_dir = 0; m_tc = 1; end
                    else m_count = m_count + 1;
                end else begin
                    if (m_count > top) m_count = top;
                    else if (m_count == 0) begin m_count = 1; m_dir = 1; m_tc = 1; end
                    else m_count = m_count - 1;
                end
            end
        end
        if (wrap_clr) begin
            m_wc8 = 0; m_wc2 = 0;
        end else if (m_tc) begin
            if (m_wc8 < 255) m_wc8 = m_wc8 + 1;
            if (m_wc2 < 3)   m_wc2 = m_wc2 + 1;
        end
    endtask

    // ---------------- scoreboard ----------------
    localparam int EW = 16;
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge: update the model at the edge, then compare both DUTs
    // just after it.
    task automatic step();
        logic [EW-1:0] e;
        @(posedge clk);
        model_update();
        exp_q.push_back({4'(m_count), m_dir, m_tc, 8'(m_wc8), 2'(m_wc2)});
        #1;
        e = exp_q.pop_front();
        check("count",     {28'd0, bus8.count},    {28'd0, e[15:12]});
        check("dir",       {31'd0, bus8.dir},      {31'd0, e[11]});
        check("tc",        {31'd0, bus8.tc},       {31'd0, e[10]});
        check("wrap_cnt",  {24'd0, bus8.wrap_cnt}, {24'd0, e[9:2]});
        check("w2_count",  {28'd0, bus2.count},    {28'd0, e[15:12]});
        check("w2_wrap",   {30'd0, bus2.wrap_cnt}, {30'd0, e[1:0]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v; en = 1'b0;
        step();
        load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0; wrap_clr = 1'b0;
        load_val = '0; n = 4'd10; mode = 2'b00;

        // 1: reset, then up count modulo 10 for 25 edges
        step(); step();
        check("rst_count", {28'd0, bus8.count}, 32'd0);
        check("rst_dir",   {31'd0, bus8.dir},   32'd1);
        check("rst_wrap",  {24'd0, bus8.wrap_cnt}, 32'd0);
        reset = 1'b1; mode = 2'b00; n = 4'd10; en = 1'b1;
        repeat (25) step();
        check("t1_count", {28'd0, bus8.count}, 32'd5);
        check("t1_wrap",  {24'd0, bus8.wrap_cnt}, 32'd2);

        // 2: down modulo 6 from a loaded 2 -> 1, 0, 5 (tc)
        mode = 2'b01; n = 4'd6;
        do_load(4'd2);
        en = 1'b1;
        repeat (3) step();
        check("t2_count", {28'd0, bus8.count}, 32'd5);
        check("t2_tc",    {31'd0, bus8.tc},    32'd1);
        check("t2_dir",   {31'd0, bus8.dir},   32'd0);

        // 3: bounce modulo 4 from 0, then a modulus of 1
        do_reset();
        mode = 2'b10; n = 4'd4; en = 1'b1;
        repeat (6) step();
        check("t3_count0", {28'd0, bus8.count}, 32'd0);
        check("t3_dir0",   {31'd0, bus8.dir},   32'd0);
        step();
        check("t3_count1", {28'd0, bus8.count}, 32'd1);
        check("t3_tc1",    {31'd0, bus8.tc},    32'd1);
        n = 4'd1;
        repeat (3) step();
        check("t3_m1_count", {28'd0, bus8.count}, 32'd0);
        check("t3_m1_tc",    {31'd0, bus8.tc},    32'd1);

        // 4: out-of-range count after n shrinks, then full-range wrap
        n = 4'd8; mode = 2'b00;
        do_load(4'd12); en = 1'b1; step();
        check("t4_up_count", {28'd0, bus8.count}, 32'd0);
        check("t4_up_tc",    {31'd0, bus8.tc},    32'd1);
        mode = 2'b01;
        do_load(4'd12); en = 1'b1; step();
        check("t4_dn_count", {28'd0, bus8.count}, 32'd7);
        check("t4_dn_tc",    {31'd0, bus8.tc},    32'd0);
        n = 4'd0; mode = 2'b00;
        do_load(4'd0); en = 1'b1;
        repeat (15) step();
        check("t4_full15", {28'd0, bus8.count}, 32'd15);
        step();
        check("t4_full_wrap", {31'd0, bus8.tc}, 32'd1);

        // 5: priority checks
        n = 4'd10; mode = 2'b00; en = 1'b1; load = 1'b1; load_val = 4'd9;
        step();
        check("t5_load_over_en", {28'd0, bus8.count}, 32'd9);
        reset = 1'b0; step();
        check("t5_rst_over_load", {28'd0, bus8.count}, 32'd0);
        reset = 1'b1; load = 1'b0; step();
        en = 1'b0; step();
        check("t5_hold_count", {28'd0, bus8.count}, 32'd1);
        check("t5_hold_tc",    {31'd0, bus8.tc},    32'd0);
        mode = 2'b10; en = 1'b1;
        repeat (4) step();
        check("t5_bounce5", {28'd0, bus8.count}, 32'd5);
        do_reset();
        check("t5_rst_count", {28'd0, bus8.count}, 32'd0);
        check("t5_rst_dir",   {31'd0, bus8.dir},   32'd1);

        // 6: saturation of the 2-bit wrap counter, then clear beats tc
        wrap_clr = 1'b1; en = 1'b0; step(); wrap_clr = 1'b0;
        mode = 2'b00; n = 4'd2; en = 1'b1;
        repeat (10) step();
        check("t6_w2_sat", {30'd0, bus2.wrap_cnt}, 32'd3);
        check("t6_w8_cnt", {24'd0, bus8.wrap_cnt}, 32'd5);
        step();
        wrap_clr = 1'b1; step(); wrap_clr = 1'b0;
        check("t6_clr_tc",  {31'd0, bus8.tc},       32'd1);
        check("t6_clr_w8",  {24'd0, bus8.wrap_cnt}, 32'd0);
        check("t6_clr_w2",  {30'd0, bus2.wrap_cnt}, 32'd0);

        // Random phase
        repeat (800) begin
            reset    = ($urandom_range(0, 59) != 0);
            load     = ($urandom_range(0, 9) == 0);
            load_val = W'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) n = W'($urandom_range(0, 15));
            wrap_clr = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
